key_updown_cnt: RTL and testbench

Debounced push-button up/down counter that produces the display value for the six-digit seven-segment driver. It takes three raw active-low buttons (up, down, clear), debounces them, and holds a signed count in the range ±MAX_MAG. The count is presented as magnitude plus sign, with fixed decimal-point and enable outputs, wired directly to the driver's `data`, `sign`, `point` and `en` inputs.

---
 rtl/key_updown_cnt.sv | 162 ++++++++++++++++
 tb/tb_key_updown_cnt.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_updown_cnt.sv
// Debounced up/down/clear push-button counter feeding a six-digit seven-segment driver.
// Optional auto-repeat on held up/down keys is built when KEY_AUTOREPEAT_EN is defined.
module key_updown_cnt #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000,
  parameter logic [25:0] REPEAT_DLY   = 26'd25_000_000,
  parameter logic [23:0] REPEAT_PER   = 24'd5_000_000,
  parameter logic [13:0] MAX_MAG      = 14'd9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_clr,
  output logic [19:0] data,
  output logic        sign,
  output logic [5:0]  point,
  output logic        en
);

  localparam logic signed [14:0] MAX_S = $signed({1'b0, MAX_MAG});

  logic [2:0] key_raw;
  logic [2:0] press;
  logic [2:0] held;
  logic [1:0] rep;

  assign key_raw = {key_clr, key_down, key_up};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic        sync1_q, sync1_d;
      logic        sync2_q, sync2_d;
      logic        stable_q, stable_d;
      logic        stable_prev_q, stable_prev_d;
      logic [19:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d       = key_raw[gi];
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = 20'd0;
        if (sync2_q != stable_q) begin
          if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
            stable_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_q       <= 1'b1;
          sync2_q       <= 1'b1;
          stable_q      <= 1'b1;
          stable_prev_q <= 1'b1;
          cnt_q         <= 20'd0;
        end else begin
          sync1_q       <= sync1_d;
          sync2_q       <= sync2_d;
          stable_q      <= stable_d;
          stable_prev_q <= stable_prev_d;
          cnt_q         <= cnt_d;
        end
      end

      assign press[gi] = stable_prev_q & ~stable_q;
      assign held[gi]  = ~stable_q;
    end
  endgenerate

`ifdef KEY_AUTOREPEAT_EN
  // hold_q counts cycles since the last press/repeat event while the key stays down
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rep
      logic [25:0] hold_q, hold_d;
      logic        in_rep_q, in_rep_d;
      logic        fire;

      always_comb begin
        fire     = 1'b0;
        hold_d   = 26'd0;
        in_rep_d = 1'b0;
        if (held[gi] && !press[2]) begin
          in_rep_d = in_rep_q;
          if ((!in_rep_q && hold_q == REPEAT_DLY) ||
              (in_rep_q && hold_q == {2'b00, REPEAT_PER})) begin
            fire     = 1'b1;
            hold_d   = 26'd1;
            in_rep_d = 1'b1;
          end else begin
            hold_d = hold_q + 26'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hold_q   <= 26'd0;
          in_rep_q <= 1'b0;
        end else begin
          hold_q   <= hold_d;
          in_rep_q <= in_rep_d;
        end
      end

      assign rep[gi] = fire;
    end
  endgenerate
`else
  assign rep = 2'b00;
`endif

  logic signed [14:0] count_q, count_d;
  logic signed [14:0] count_neg;
  logic [13:0]        mag;
  logic [19:0]        data_q, data_d;
  logic               sign_q, sign_d;
  logic               en_q, en_d;
  logic               up_ev, dn_ev;

  always_comb begin
    up_ev   = press[0] | rep[0];
    dn_ev   = press[1] | rep[1];
    count_d = count_q;
    if (press[2]) begin
      count_d = 15'sd0;
    end else if (up_ev && !dn_ev) begin
      if (count_q != MAX_S) count_d = count_q + 15'sd1;
    end else if (dn_ev && !up_ev) begin
      if (count_q != -MAX_S) count_d = count_q - 15'sd1;
    end
    // outputs track count_d so the display updates on the same edge as the count
    count_neg = -count_d;
    mag       = count_d[14] ? count_neg[13:0] : count_d[13:0];
    data_d    = {6'd0, mag};
    sign_d    = count_d[14];
    en_d      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 15'sd0;
      data_q  <= 20'd0;
      sign_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      sign_q  <= sign_d;
      en_q    <= en_d;
    end
  end

  assign data  = data_q;
  assign sign  = sign_q;
  assign en    = en_q;
  assign point = 6'b000000;

endmodule

// File: tb/tb_key_updown_cnt.sv
// Self-checking bench for key_updown_cnt: directed scenarios plus randomized key traffic
// checked against a saturating-integer reference model.
module tb_key_updown_cnt;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_up = 1'b1;
  logic        key_down = 1'b1;
  logic        key_clr = 1'b1;
  logic [19:0] data;
  logic        sign;
  logic [5:0]  point;
  logic        en;

  int checks = 0;
  int errors = 0;
  int model  = 0;
  localparam int MAXM = 5;

  always #5 clk = ~clk;

  key_updown_cnt #(
    .DEBOUNCE_CYC(20'd4),
    .REPEAT_DLY  (26'd8),
    .REPEAT_PER  (24'd4),
    .MAX_MAG     (14'd5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_up  (key_up),
    .key_down(key_down),
    .key_clr (key_clr),
    .data    (data),
    .sign    (sign),
    .point   (point),
    .en      (en)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    int mag;
    mag = (model < 0) ? -model : model;
    chk({tag, "_data"}, {12'd0, data}, mag);
    chk({tag, "_sign"}, {31'd0, sign}, (model < 0) ? 1 : 0);
  endtask

  // mask bit0 = up, bit1 = down, bit2 = clr (1 = pressed)
  task automatic set_keys(input logic [2:0] m);
    key_up   = ~m[0];
    key_down = ~m[1];
    key_clr  = ~m[2];
  endtask

  task automatic apply_model(input logic [2:0] m);
    if (m[2])                model = 0;
    else if (m[0] && !m[1])  model = (model < MAXM) ? model + 1 : model;
    else if (m[1] && !m[0])  model = (model > -MAXM) ? model - 1 : model;
  endtask

  task automatic press(input logic [2:0] m, input int len);
    set_keys(m);
    tick(len);
    set_keys(3'b000);
    tick(10);
    apply_model(m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0] m;
    int         kind;

    // reset state
    rst_n = 1'b0;
    tick(3);
    chk("rst_en",    {31'd0, en}, 0);
    chk("rst_data",  {12'd0, data}, 0);
    chk("rst_sign",  {31'd0, sign}, 0);
    chk("rst_point", {26'd0, point}, 0);
    rst_n = 1'b1;
    tick(1);
    chk("en_first", {31'd0, en}, 1);
    tick(19);
    chk_model("idle");
    chk("idle_point", {26'd0, point}, 0);

    // first step lands exactly at E0+6
    set_keys(3'b001);
    tick(6);
    chk("pre_e0_6", {12'd0, data}, 0);
    tick(1);
    chk("at_e0_6", {12'd0, data}, 1);
    tick(1);
    set_keys(3'b000);
    tick(10);
    model = 1;
    press(3'b001, 8);
    press(3'b001, 8);
    chk_model("three_ups");

    // 3-cycle glitch must not count
    set_keys(3'b001);
    tick(3);
    set_keys(3'b000);
    tick(10);
    chk_model("glitch");

    // down from zero goes negative
    press(3'b100, 8);
    chk_model("clr0");
    press(3'b010, 8);
    chk_model("down_neg");

    // saturation both directions
    press(3'b100, 8);
    repeat (8) press(3'b001, 8);
    chk_model("sat_pos");
    repeat (11) press(3'b010, 8);
    chk_model("sat_neg");

    // simultaneous events
    press(3'b100, 8);
    press(3'b001, 8);
    press(3'b001, 8);
    press(3'b011, 8);
    chk_model("up_dn_same");
    press(3'b101, 8);
    chk_model("clr_up_same");

    // reset mid-operation with key held: counts afresh after release of reset
    press(3'b001, 8);
    press(3'b001, 8);
    set_keys(3'b001);
    tick(4);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_data", {12'd0, data}, 0);
    chk("midrst_en",   {31'd0, en}, 0);
    rst_n = 1'b1;
    tick(8);
    set_keys(3'b000);
    tick(10);
    model = 1;
    chk_model("held_thru_rst");

    // long hold: auto-repeat when built, single step otherwise
    press(3'b100, 8);
    set_keys(3'b001);
    tick(7);
    chk("hold_first", {12'd0, data}, 1);
    tick(8);
`ifdef KEY_AUTOREPEAT_EN
    chk("hold_rep1", {12'd0, data}, 2);
`else
    chk("hold_rep1", {12'd0, data}, 1);
`endif
    tick(22);
    set_keys(3'b000);
    tick(12);
`ifdef KEY_AUTOREPEAT_EN
    model = 5;
`else
    model = 1;
`endif
    chk_model("hold_long");

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      m    = 3'($urandom_range(1, 7));
      if (kind == 0) begin
        set_keys(m);
        tick($urandom_range(1, 3));
        set_keys(3'b000);
        tick(8);
      end else begin
        press(m, $urandom_range(5, 8));
      end
      chk_model($sformatf("rnd%0d_k%0d_m%0d", i, kind, m));
    end
    chk("final_en",    {31'd0, en}, 1);
    chk("final_point", {26'd0, point}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
